button_events: RTL and testbench

- Consumes the debouncer's stable level (`flag`) and its unstable indicator (`floating`).
- Turns them into single-cycle key events for the HD44780 menu/control logic: press, release, long-press and auto-repeat.
- Sits directly downstream of one debouncer instance; one instance per button.

---
 rtl/button_events.sv | 131 +++++++++++++
 tb/tb_button_events.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/button_events.sv
// Turns a debounced button level into single-cycle press / release / long-press /
// auto-repeat events. One instance per button, fed directly by its debouncer.
module button_events #(
    parameter logic INVERT       = 1'b0,
    parameter int   CNT_WIDTH    = 24,
    parameter int   LONG_COUNT   = 1000000,
    parameter int   REPEAT_COUNT = 250000,
    parameter logic REPEAT_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level,
    input  logic       floating,
    output logic       press,
    output logic       key_release,
    output logic       long_press,
    output logic       key_repeat,
    output logic       held,
    output logic [1:0] state_dbg
);

    // "release" and "repeat" are language keywords, hence the key_ prefix on those ports.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LONG_TC   = CNT_WIDTH'(LONG_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_TC = CNT_WIDTH'(REPEAT_COUNT - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic                 long_q, long_d;
    logic                 repeat_q, repeat_d;
    logic                 held_q, held_d;

    logic valid;
    logic pressed;

    assign valid   = ~floating;
    assign pressed = level ^ INVERT;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        // Floating edges freeze everything, which stretches the hold intervals.
        if (valid) begin
            case (state_q)
                IDLE: begin
                    if (pressed) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else if (cnt_q == LONG_TC) begin
                        state_d = REPEAT;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                REPEAT: begin
                    if (!pressed) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else if (REPEAT_EN) begin
                        if (cnt_q == REPEAT_TC) begin
                            cnt_d    = '0;
                            repeat_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Registered from the next state so it rises with press and falls with release.
        held_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press       = press_q;
    assign key_release = release_q;
    assign long_press  = long_q;
    assign key_repeat  = repeat_q;
    assign held        = held_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: instance a (INVERT=0, repeat on) and
// instance b (INVERT=1, repeat off), both with LONG_COUNT=8, REPEAT_COUNT=4.
module tb_button_events;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HELD = 2'd1;
    localparam logic [1:0] S_RPT  = 2'd2;

    logic       clk;
    logic       rst_n;
    logic       a_level, a_float, b_level, b_float;
    logic       a_press, a_rel, a_long, a_rep, a_held;
    logic       b_press, b_rel, b_long, b_rep, b_held;
    logic [1:0] a_state, b_state;
    logic [6:0] a_obs, b_obs;

    int checks = 0;
    int errors = 0;

    button_events #(
        .INVERT(1'b0), .CNT_WIDTH(24), .LONG_COUNT(8), .REPEAT_COUNT(4), .REPEAT_EN(1'b1)
    ) u_a (
        .clk(clk), .rst(rst_n), .level(a_level), .floating(a_float),
        .press(a_press), .key_release(a_rel), .long_press(a_long), .key_repeat(a_rep),
        .held(a_held), .state_dbg(a_state)
    );

    button_events #(
        .INVERT(1'b1), .CNT_WIDTH(24), .LONG_COUNT(8), .REPEAT_COUNT(4), .REPEAT_EN(1'b0)
    ) u_b (
        .clk(clk), .rst(rst_n), .level(b_level), .floating(b_float),
        .press(b_press), .key_release(b_rel), .long_press(b_long), .key_repeat(b_rep),
        .held(b_held), .state_dbg(b_state)
    );

    assign a_obs = {a_press, a_rel, a_long, a_rep, a_held, a_state};
    assign b_obs = {b_press, b_rel, b_long, b_rep, b_held, b_state};

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] ev(input logic p, input logic r, input logic l,
                                      input logic rp, input logic h, input logic [1:0] st);
        return {p, r, l, rp, h, st};
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        a_level = 1'b0;
        a_float = 1'b0;
        b_level = 1'b1;
        b_float = 1'b0;

        // reset state
        #1;
        chk("reset_a", a_obs, ev(0, 0, 0, 0, 0, S_IDLE));
        chk("reset_b", b_obs, ev(0, 0, 0, 0, 0, S_IDLE));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_a", a_obs, ev(0, 0, 0, 0, 0, S_IDLE));
        chk("post_reset_b", b_obs, ev(0, 0, 0, 0, 0, S_IDLE));

        // short press: 5 cycles high
        a_level = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("short i=%0d", i), a_obs, ev(i == 0, 0, 0, 0, 1, S_HELD));
        end
        a_level = 1'b0;
        tick();
        chk("short_release", a_obs, ev(0, 1, 0, 0, 0, S_IDLE));
        tick();
        chk("short_idle", a_obs, ev(0, 0, 0, 0, 0, S_IDLE));

        // long press with repeat: long at +8, repeats at +12, +16
        a_level = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("long i=%0d", i), a_obs,
                ev(i == 0, 0, i == 8, (i == 12) || (i == 16), 1, (i < 8) ? S_HELD : S_RPT));
        end
        a_level = 1'b0;
        tick();
        chk("long_release", a_obs, ev(0, 1, 0, 0, 0, S_IDLE));
        chk("b_quiet", b_obs, ev(0, 0, 0, 0, 0, S_IDLE));

        // floating freeze: floating edges 2..4 with level toggling -> long at +11;
        // then release lands on the repeat terminal count at +15
        a_level = 1'b1;
        tick();
        chk("float i=0", a_obs, ev(1, 0, 0, 0, 1, S_HELD));
        for (int i = 1; i < 15; i++) begin
            a_float = (i >= 2) && (i <= 4);
            a_level = a_float ? ((i % 2) == 1) : 1'b1;
            tick();
            chk($sformatf("float i=%0d", i), a_obs,
                ev(0, 0, i == 11, 0, 1, (i < 11) ? S_HELD : S_RPT));
        end
        a_float = 1'b0;
        a_level = 1'b0;
        tick();
        chk("repeat_collision", a_obs, ev(0, 1, 0, 0, 0, S_IDLE));

        // terminal-count collision: release sampled when cnt==7
        a_level = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("tc i=%0d", i), a_obs, ev(i == 0, 0, 0, 0, 1, S_HELD));
        end
        a_level = 1'b0;
        tick();
        chk("long_collision", a_obs, ev(0, 1, 0, 0, 0, S_IDLE));
        tick();
        chk("long_collision_after", a_obs, ev(0, 0, 0, 0, 0, S_IDLE));

        // async reset while the repeat pulse is high
        a_level = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk($sformatf("rst_hold i=%0d", i), a_obs,
                ev(i == 0, 0, i == 8, i == 12, 1, (i < 8) ? S_HELD : S_RPT));
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_a", a_obs, ev(0, 0, 0, 0, 0, S_IDLE));
        chk("async_reset_b", b_obs, ev(0, 0, 0, 0, 0, S_IDLE));
        tick();
        tick();
        chk("in_reset_a", a_obs, ev(0, 0, 0, 0, 0, S_IDLE));
        rst_n = 1'b1;
        tick();
        chk("powerup_press", a_obs, ev(1, 0, 0, 0, 1, S_HELD));
        a_level = 1'b0;
        tick();
        chk("powerup_release", a_obs, ev(0, 1, 0, 0, 0, S_IDLE));

        // inverted polarity, repeat disabled
        b_level = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("inv i=%0d", i), b_obs,
                ev(i == 0, 0, i == 8, 0, 1, (i < 8) ? S_HELD : S_RPT));
        end
        b_level = 1'b1;
        tick();
        chk("inv_release", b_obs, ev(0, 1, 0, 0, 0, S_IDLE));
        tick();
        chk("inv_idle", b_obs, ev(0, 0, 0, 0, 0, S_IDLE));
        chk("a_idle_end", a_obs, ev(0, 0, 0, 0, 0, S_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
